// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and constants for the fetch-side PC redirect logic.
package pc_redirect_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  localparam int PC_INC = 4;

  // Comparator function codes, shared with the execute-stage comparator.
  localparam logic [3:0] BR_EQZ = 4'b0000;
  localparam logic [3:0] BR_LTZ = 4'b0001;
  localparam logic [3:0] BR_GTZ = 4'b0010;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
interface pc_redirect_unit_if #(
  parameter int PC_W = 32
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;

  modport master (output req, output addr, input ack);
  modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/pc_redirect_unit_flush_timer.sv
// Loadable down-counter holding flush high for CYCLES cycles after each load.
module flush_timer #(
  parameter int CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  output logic o_flush,
  output logic o_done
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)             r_cnt <= '0;
    else if (i_load)         r_cnt <= CW'(CYCLES);
    else if (r_cnt != '0)    r_cnt <= r_cnt - CW'(1);
  end

  assign o_flush = (r_cnt != '0);
  assign o_done  = (r_cnt == CW'(1));
endmodule

// File: rtl/pc_redirect_unit.sv
// Owns the fetch PC, drives the imem req/ack handshake, and redirects and
// squashes wrong-path fetches on taken branches from the execute stage.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_br_valid,
  input  logic               i_br_taken,
  input  logic [PC_W-1:0]    i_br_target,
  input  logic               i_stall,
  pc_redirect_unit_if.master io_imem,
  output logic               o_if_valid,
  output logic [PC_W-1:0]    o_if_pc,
  output logic               o_flush,
  output logic               o_br_misalign
);
  state_e          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, r_old_addr, r_if_pc, w_addr;
  logic            r_drop, r_if_valid, r_misalign;
  logic            w_req, w_redirect, w_accept, w_deliver, w_timer_done;

  assign w_redirect = i_br_valid & i_br_taken & (r_state != S_IDLE);
  // An ack arriving while dropping belongs to the abandoned address.
  assign w_accept   = (r_state == S_FETCH) & io_imem.ack & ~r_drop & ~w_redirect;
  assign w_deliver  = (w_accept & ~i_stall)
                    | ((r_state == S_HOLD) & ~i_stall & ~w_redirect);

  flush_timer #(.CYCLES(FLUSH_CYCLES)) u_flush_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_redirect),
    .o_flush (o_flush),
    .o_done  (w_timer_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: if (w_redirect)            w_state_nxt = S_FLUSH;
               else if (w_accept & i_stall) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_redirect)            w_state_nxt = S_FLUSH;
               else if (!i_stall)         w_state_nxt = S_FETCH;
      S_FLUSH: if (w_redirect)            w_state_nxt = S_FLUSH;
               else if (w_timer_done)     w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A dropped request keeps presenting its old address until acked.
  always_comb begin
    w_req  = (r_state == S_FETCH) | r_drop;
    w_addr = r_drop ? r_old_addr : r_pc;
  end

  assign io_imem.req  = w_req;
  assign io_imem.addr = w_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_old_addr <= '0;
      r_drop     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_if_valid <= w_deliver;
      r_misalign <= w_redirect & (i_br_target[1:0] != 2'b00);
      r_drop     <= w_req & ~io_imem.ack & (r_drop | w_redirect);
      r_old_addr <= w_addr;
      if (w_redirect) begin
        r_pc <= {i_br_target[PC_W-1:2], 2'b00};
      end else if (w_deliver) begin
        r_pc    <= r_pc + PC_W'(PC_INC);
        r_if_pc <= r_pc;
      end
    end
  end

  assign o_if_valid    = r_if_valid;
  assign o_if_pc       = r_if_pc;
  assign o_br_misalign = r_misalign;
endmodule
